// File: rtl/picosoc_mem_ctrl.sv
// PicoRV32 native-bus to byte-laned synchronous SRAM controller.
// Optional post-reset zero sweep enabled by defining PICOSOC_MEM_CLEAR_EN.
module picosoc_mem_ctrl #(
  parameter int          WORDS     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [3:0]  ram_wen,
  output logic [21:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // 33-bit window bounds so a region ending at 4 GiB does not wrap
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + (33'(WORDS) << 2);

`ifdef PICOSOC_MEM_CLEAR_EN
  localparam state_t      RST_STATE = CLEAR;
  localparam logic [21:0] LAST_WORD = 22'(WORDS - 1);
`else
  localparam state_t      RST_STATE = IDLE;
`endif

  state_t      r_state;
  state_t      w_next;
  logic        w_hit;
  logic        w_accept;
  logic [21:0] w_idx;
  logic [21:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [3:0]  r_ram_wen;
  logic        r_rd;

  assign w_hit =
    ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) &&
    ({1'b0, mem_addr} < LIMIT);
  assign w_idx = 22'((mem_addr - BASE_ADDR) >> 2);
  assign w_accept =
    (r_state == IDLE) && mem_valid && w_hit;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RST_STATE;
    else       r_state <= w_next;
  end

`ifdef PICOSOC_MEM_CLEAR_EN
  logic [21:0] r_clr_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_clr_cnt <= '0;
    else if (r_state == CLEAR)
      r_clr_cnt <= r_clr_cnt + 22'd1;
  end
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CLEAR: begin
`ifdef PICOSOC_MEM_CLEAR_EN
        if (r_clr_cnt == LAST_WORD) w_next = IDLE;
`else
        w_next = IDLE;
`endif
      end
      IDLE:    if (mem_valid && w_hit) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields are captured only on the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wen   <= '0;
      r_rd        <= 1'b0;
    end else if (w_accept) begin
      r_ram_addr  <= w_idx;
      r_ram_wdata <= mem_wdata;
      r_ram_wen   <= mem_wstrb;
      r_rd        <= (mem_wstrb == 4'h0);
    end else if (r_state == ACCESS) begin
      r_ram_wen   <= '0;
    end
  end

  always_comb begin
    mem_ready = (r_state == RESP);
    mem_rdata = '0;
    if ((r_state == RESP) && r_rd)
      mem_rdata = ram_rdata;
    busy      = 1'b0;
    ram_wen   = r_ram_wen;
    ram_addr  = r_ram_addr;
    ram_wdata = r_ram_wdata;
`ifdef PICOSOC_MEM_CLEAR_EN
    // Sweep lanes stay off while reset is still held
    if (r_state == CLEAR) begin
      busy      = 1'b1;
      ram_wen   = reset ? 4'h0 : 4'hF;
      ram_addr  = r_clr_cnt;
      ram_wdata = '0;
    end
`endif
  end

endmodule
